instruction_fetch_unit: RTL and testbench

Fetch stage directly downstream of the program counter. Takes the PC address, runs a request/acknowledge transaction with the instruction memory, and holds the fetched word in an instruction register. It presents that word, with its opcode and func fields, to decode and branch logic through a valid/ready handshake. On each hand-off it pulses the load strobe that advances the program counter, and it flags misaligned and timed-out fetches.

---
 rtl/instruction_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Fetch stage between the program counter and decode. It latches the PC,
// runs a request/acknowledge transaction with instruction memory and holds
// the returned word until the consumer takes it. Misaligned and timed-out
// fetches raise a sticky fault that only flush or reset clears.

module instruction_fetch_unit #(
  parameter int ADDR_SIZE  = 64,
  parameter int INSTR_SIZE = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  fetch_en,
  input  logic                  flush,
  input  logic [ADDR_SIZE-1:0]  pc_addr,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_SIZE-1:0] imem_rdata,
  output logic [INSTR_SIZE-1:0] instr,
  output logic [6:0]            opcode,
  output logic [2:0]            func,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  pc_load,
  output logic                  fault,
  output logic [1:0]            fault_cause
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;

  // Decode fields are plain slices of the held instruction word.
  assign opcode = instr[6:0];
  assign func   = instr[14:12];

  // The PC advances only on a genuine hand-off; a flush in the same cycle cancels it.
  assign pc_load = instr_valid & instr_ready & ~flush;

  // Fetch sequencer: flush outranks everything; an ack beats a coincident timeout.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      counter     <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else if (flush) begin
      state       <= IDLE;
      counter     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            if (pc_addr[1:0] != 2'b00) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              state       <= FAULT;
            end else begin
              imem_addr <= pc_addr;
              imem_req  <= 1'b1;
              counter   <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else if (counter == CNT_MAX) begin
            imem_req    <= 1'b0;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= FAULT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Drives scripted and randomized fetches into instruction_fetch_unit and
// compares every observable output against outcomes predicted from the
// fetch rules (alignment, ack latency vs. timeout window, consumer delay).

module tb_instruction_fetch_unit;

  localparam int ADDR_SIZE  = 64;
  localparam int INSTR_SIZE = 32;
  localparam int TIMEOUT    = 16;

  logic                  CLK;
  logic                  RST;
  logic                  fetch_en;
  logic                  flush;
  logic [ADDR_SIZE-1:0]  pc_addr;
  logic                  imem_req;
  logic [ADDR_SIZE-1:0]  imem_addr;
  logic                  imem_ack;
  logic [INSTR_SIZE-1:0] imem_rdata;
  logic [INSTR_SIZE-1:0] instr;
  logic [6:0]            opcode;
  logic [2:0]            func;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  pc_load;
  logic                  fault;
  logic [1:0]            fault_cause;

  int checks;
  int failures;

  instruction_fetch_unit #(
    .ADDR_SIZE (ADDR_SIZE),
    .INSTR_SIZE(INSTR_SIZE),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .pc_addr    (pc_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .opcode     (opcode),
    .func       (func),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_load    (pc_load),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete fetch; the expected outcome is decided up front from the
  // address alignment and the ack latency (w idle REQ cycles before ack).
  task automatic run_fetch(input logic [ADDR_SIZE-1:0] addr, input int w,
                           input int rd, input logic [INSTR_SIZE-1:0] data);
    bit misaligned;
    bit captured;
    bit acked;
    misaligned = (addr[1:0] != 2'b00);
    captured   = !misaligned && (w < TIMEOUT);
    acked      = 1'b0;
    pc_addr  = addr;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    if (misaligned) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL mis_req got=%b exp=0", imem_req); end
      checks++; if (fault !== 1'b1) begin failures++; $display("[TB] FAIL mis_fault got=%b exp=1", fault); end
      checks++; if (fault_cause !== 2'b01) begin failures++; $display("[TB] FAIL mis_cause got=%b exp=01", fault_cause); end
      pc_addr  = {$urandom, $urandom} & ~64'h3;
      fetch_en = 1'b1;
      tick();
      tick();
      fetch_en = 1'b0;
      checks++; if (imem_req !== 1'b0 || fault !== 1'b1) begin failures++; $display("[TB] FAIL mis_ignore req=%b fault=%b exp req=0 fault=1", imem_req, fault); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin failures++; $display("[TB] FAIL mis_flush fault=%b cause=%b exp 0/00", fault, fault_cause); end
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== addr) begin failures++; $display("[TB] FAIL req_phase cycle=%0d req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, addr); end
      checks++; if (fault !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL req_quiet cycle=%0d fault=%b valid=%b exp 0/0", k, fault, instr_valid); end
      pc_addr    = {$urandom, $urandom};
      imem_rdata = $urandom;
      if (k == w + 1) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        acked      = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (acked !== captured) begin failures++; $display("[TB] FAIL outcome acked=%b exp=%b", acked, captured); end
    if (!captured) begin
      checks++; if (fault !== 1'b1 || fault_cause !== 2'b10) begin failures++; $display("[TB] FAIL timeout fault=%b cause=%b exp 1/10", fault, fault_cause); end
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL timeout_req req=%b valid=%b exp 0/0", imem_req, instr_valid); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin failures++; $display("[TB] FAIL timeout_flush fault=%b cause=%b exp 0/00", fault, fault_cause); end
      return;
    end
    checks++; if (instr_valid !== 1'b1 || instr !== data) begin failures++; $display("[TB] FAIL capture valid=%b instr=%h exp 1/%h", instr_valid, instr, data); end
    checks++; if (opcode !== data[6:0] || func !== data[14:12]) begin failures++; $display("[TB] FAIL fields opcode=%h func=%b exp %h/%b", opcode, func, data[6:0], data[14:12]); end
    checks++; if (imem_req !== 1'b0 || fault !== 1'b0) begin failures++; $display("[TB] FAIL capture_req req=%b fault=%b exp 0/0", imem_req, fault); end
    for (int r = 0; r < rd; r++) begin
      instr_ready = 1'b0;
      #1;
      checks++; if (pc_load !== 1'b0 || instr_valid !== 1'b1 || instr !== data) begin failures++; $display("[TB] FAIL backpressure cyc=%0d load=%b valid=%b instr=%h exp 0/1/%h", r, pc_load, instr_valid, instr, data); end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    checks++; if (pc_load !== 1'b1) begin failures++; $display("[TB] FAIL handoff_load got=%b exp=1", pc_load); end
    tick();
    #1;
    checks++; if (instr_valid !== 1'b0 || pc_load !== 1'b0) begin failures++; $display("[TB] FAIL after_handoff valid=%b load=%b exp 0/0", instr_valid, pc_load); end
    checks++; if (instr !== data) begin failures++; $display("[TB] FAIL instr_kept got=%h exp=%h", instr, data); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0 || imem_addr !== '0) begin failures++; $display("[TB] FAIL reset_req req=%b addr=%h exp 0/0", imem_req, imem_addr); end
    checks++; if (instr !== '0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_instr instr=%h valid=%b exp 0/0", instr, instr_valid); end
    checks++; if (fault !== 1'b0 || fault_cause !== 2'b00 || pc_load !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault fault=%b cause=%b load=%b exp 0/00/0", fault, fault_cause, pc_load); end
    RST = 1'b1;
  endtask

  task automatic test_single_fetch();
    pc_addr  = 64'h100;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin failures++; $display("[TB] FAIL single_req req=%b addr=%h exp 1/100", imem_req, imem_addr); end
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A00093;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A00093) begin failures++; $display("[TB] FAIL single_instr valid=%b instr=%h exp 1/00a00093", instr_valid, instr); end
    checks++; if (opcode !== 7'h13 || func !== 3'b000) begin failures++; $display("[TB] FAIL single_fields opcode=%h func=%b exp 13/000", opcode, func); end
    instr_ready = 1'b1;
    #1;
    checks++; if (pc_load !== 1'b1) begin failures++; $display("[TB] FAIL single_load got=%b exp=1", pc_load); end
    tick();
    checks++; if (pc_load !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse load=%b valid=%b exp 0/0", pc_load, instr_valid); end
    instr_ready = 1'b0;
  endtask

  task automatic test_wait_backpressure();
    run_fetch(64'h2000, 4, 3, 32'h12345067);
  endtask

  task automatic test_misaligned();
    run_fetch(64'h102, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    run_fetch(64'h300, TIMEOUT + 5, 0, 32'h0);
    run_fetch(64'h304, TIMEOUT - 1, 1, 32'hCAFE5013);
  endtask

  task automatic test_flush_collision();
    pc_addr  = 64'h400;
    fetch_en = 1'b1;
    tick();
    fetch_en   = 1'b0;
    flush      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    tick();
    flush    = 1'b0;
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL flush_ack valid=%b req=%b exp 0/0", instr_valid, imem_req); end
    tick();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle req=%b valid=%b exp 0/0", imem_req, instr_valid); end
    run_fetch(64'h408, 0, 0, 32'h00B00113);
    pc_addr  = 64'h500;
    fetch_en = 1'b1;
    tick();
    fetch_en   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h00C00193;
    tick();
    imem_ack    = 1'b0;
    flush       = 1'b1;
    instr_ready = 1'b1;
    #1;
    checks++; if (pc_load !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready_load got=%b exp=0", pc_load); end
    tick();
    flush       = 1'b0;
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_hold_valid got=%b exp=0", instr_valid); end
  endtask

  task automatic test_reset_mid_req();
    pc_addr  = 64'h600;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== '0 || instr !== '0) begin failures++; $display("[TB] FAIL rst_mid req=%b addr=%h instr=%h exp 0/0/0", imem_req, imem_addr, instr); end
    checks++; if (instr_valid !== 1'b0 || fault !== 1'b0 || fault_cause !== 2'b00) begin failures++; $display("[TB] FAIL rst_mid_flags valid=%b fault=%b cause=%b exp 0/0/00", instr_valid, fault, fault_cause); end
    imem_ack   = 1'b1;
    imem_rdata = 32'h11111111;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== '0 || imem_req !== 1'b0) begin failures++; $display("[TB] FAIL late_ack valid=%b instr=%h req=%b exp 0/0/0", instr_valid, instr, imem_req); end
  endtask

  task automatic test_random();
    logic [ADDR_SIZE-1:0] addr;
    for (int i = 0; i < 30; i++) begin
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      run_fetch(addr, $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3), $urandom);
    end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    checks      = 0;
    failures    = 0;
    RST         = 1'b0;
    fetch_en    = 1'b0;
    flush       = 1'b0;
    pc_addr     = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_wait_backpressure();
    test_misaligned();
    test_timeout();
    test_flush_collision();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
